dmem_responder: RTL and testbench

Data-memory responder for the RISC-V core's load/store port: accepts one load or store request at a time over a valid/ready handshake and holds it for a programmable number of wait states. It then performs the byte/half/word access on an internal little-endian word array and returns read data (sign- or zero-extended) or a store completion over a second valid/ready handshake. It sits between the processor's memory stage (the MemRead/MemWrite initiator) and the data storage, and replaces the zero-latency combinational data memory so the core and benches can exercise stalled memory accesses.

---
 rtl/dmem_responder.sv | 208 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-memory responder for the core's load/store port. Accepts one
//            load/store request at a time, holds it for WAIT_CYCLES wait
//            states, performs the byte/half/word access on an internal
//            little-endian word array and returns extended load data (or a
//            store completion) over a second valid/ready handshake.
// Ports    : clk        - rising-edge clock
//            rst        - asynchronous reset, active low
//            req_valid  / req_ready  - request handshake
//            req_write  - 1 = store, 0 = load
//            req_funct3 - RISC-V funct3 (size / sign)
//            req_addr   - byte address
//            req_wdata  - store data (low byte/half used for SB/SH)
//            rsp_valid  / rsp_ready  - response handshake
//            rsp_rdata  - extended load data; 0 for stores and errors
//            rsp_err    - access faulted, no array write happened
// Config   : DMEM_MISALIGN_TRAP_EN - when defined, misaligned half/word
//            accesses fault; otherwise they are force-aligned.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic        accept, commit;
  logic        a_write;
  logic [2:0]  a_funct3;
  logic [31:0] a_addr, a_wdata;
  logic        is_byte, is_half, is_word;
  logic        legal_f3, out_of_range, misaligned, err;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wdata_lanes, rd_word, rd_shift, load_data;
  logic [AW-1:0] idx;

  assign accept = req_valid && req_ready_q;

  // Next-state logic. The access commits on the edge that enters RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the commit happens on the accept edge, so the
  // access must be decoded straight from the request inputs.
  always_comb begin
    if (state_q == S_IDLE) begin
      a_write  = req_write;
      a_funct3 = req_funct3;
      a_addr   = req_addr;
      a_wdata  = req_wdata;
    end else begin
      a_write  = write_q;
      a_funct3 = funct3_q;
      a_addr   = addr_q;
      a_wdata  = wdata_q;
    end
  end

  always_comb begin
    is_byte = (a_funct3[1:0] == 2'b00);
    is_half = (a_funct3[1:0] == 2'b01);
    is_word = (a_funct3[1:0] == 2'b10);
    if (a_write) legal_f3 = (a_funct3 == 3'b000) || (a_funct3 == 3'b001) || (a_funct3 == 3'b010);
    else         legal_f3 = (a_funct3 == 3'b000) || (a_funct3 == 3'b001) || (a_funct3 == 3'b010) ||
                            (a_funct3 == 3'b100) || (a_funct3 == 3'b101);
    out_of_range = |a_addr[31:AW+2];
`ifdef DMEM_MISALIGN_TRAP_EN
    misaligned = (is_half && a_addr[0]) || (is_word && (a_addr[1:0] != 2'b00));
    off        = a_addr[1:0];
`else
    misaligned = 1'b0;
    off        = is_word ? 2'b00 : (is_half ? {a_addr[1], 1'b0} : a_addr[1:0]);
`endif
    err = !legal_f3 || out_of_range || misaligned;
    idx = a_addr[AW+1:2];

    be          = 4'b0000;
    wdata_lanes = a_wdata;
    if (is_byte) begin
      be          = 4'b0001 << off;
      wdata_lanes = {4{a_wdata[7:0]}};
    end else if (is_half) begin
      be          = 4'b0011 << off;
      wdata_lanes = {2{a_wdata[15:0]}};
    end else if (is_word) begin
      be          = 4'b1111;
    end

    rd_word  = mem_q[idx];
    rd_shift = rd_word >> {off, 3'b000};
    case (a_funct3)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  load_data = rd_shift;
      3'b100:  load_data = {24'd0, rd_shift[7:0]};
      3'b101:  load_data = {16'd0, rd_shift[15:0]};
      default: load_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      write_q     <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      // Registered ready: low during reset and for the first edge after it.
      req_ready_q <= (state_d == S_IDLE);
      if (accept) begin
        write_q  <= req_write;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (commit) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= err;
        rsp_rdata_q <= (err || a_write) ? 32'd0 : load_data;
      end else if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // Array storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit && a_write && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder (DEPTH_WORDS=256,
//            WAIT_CYCLES=2). Expected responses are queued when a request is
//            driven and compared when the responder presents its response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int W = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  dmem_responder #(
    .DEPTH_WORDS(256),
    .WAIT_CYCLES(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request (assumed to start at posedge+1), then check latency,
  // response contents, optional back-pressure stability and the return to idle.
  task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int stall);
    exp_t e;
    int   g;
    int   lat;
    g = 0;
    while (!req_ready && g < 20) begin
      step();
      g++;
    end
    chk_val({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    rsp_ready  = (stall == 0);
    sb.push_back('{rd: exp_rd, err: exp_err});
    step();
    req_valid = 1'b0;
    req_wdata = 32'hCAFEF00D;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      step();
      lat++;
    end
    chk_val({tag, "_lat"}, 32'(lat), 32'(W + 1));
    e = sb.pop_front();
    chk_val({tag, "_rdata"}, rsp_rdata, e.rd);
    chk_val({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
    for (int i = 0; i < stall; i++) begin
      step();
      chk_val({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk_val({tag, "_hold_rdata"}, rsp_rdata, e.rd);
      chk_val({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    chk_val({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk_val({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    rsp_ready  = 1'b1;
    repeat (3) step();
    chk_val("rst_ready", {31'd0, req_ready}, 32'd0);
    chk_val("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk_val("rst_rdata", rsp_rdata, 32'd0);
    chk_val("rst_err",   {31'd0, rsp_err}, 32'd0);
    rst = 1'b1;
    step();
    chk_val("post_rst_ready", {31'd0, req_ready}, 32'd1);

    do_req("sw10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    do_req("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    do_req("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 0);
    do_req("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, 0);
    do_req("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 0);
    do_req("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 0);
    do_req("sb11",  1'b1, 3'b000, 32'h11, 32'h00000055, 32'h0, 1'b0, 0);
    do_req("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 0);
    do_req("stall", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 5);

    do_req("sw0",    1'b1, 3'b010, 32'h00, 32'hA5A5A5A5, 32'h0, 1'b0, 0);
    do_req("lw400",  1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, 0);
    do_req("f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 0);
    do_req("sf3_100",1'b1, 3'b100, 32'h00, 32'h11111111, 32'h0, 1'b1, 0);
    do_req("sw400",  1'b1, 3'b010, 32'h400, 32'h12345678, 32'h0, 1'b1, 0);
    do_req("lw0",    1'b0, 3'b010, 32'h00, 32'h0, 32'hA5A5A5A5, 1'b0, 0);

`ifdef DMEM_MISALIGN_TRAP_EN
    do_req("lw12",  1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 0);
    do_req("lh11",  1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, 0);
`else
    do_req("lw12",  1'b0, 3'b010, 32'h12, 32'h0, 32'hDEAD55EF, 1'b0, 0);
    do_req("lh11",  1'b0, 3'b001, 32'h11, 32'h0, 32'h000055EF, 1'b0, 0);
`endif

    // Reset during WAIT of a store must discard it.
    do_req("sw20",  1'b1, 3'b010, 32'h20, 32'h11111111, 32'h0, 1'b0, 0);
    do_req("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 0);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h20;
    req_wdata  = 32'h22222222;
    step();
    req_valid = 1'b0;
    chk_val("abort_in_wait", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk_val("abort_rst_ready", {31'd0, req_ready}, 32'd0);
    chk_val("abort_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk_val("abort_rst_rdata", rsp_rdata, 32'd0);
    chk_val("abort_rst_err",   {31'd0, rsp_err}, 32'd0);
    repeat (3) step();
    chk_val("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b1;
    lat = 0;
    while (!req_ready && lat < 10) begin
      step();
      lat++;
    end
    chk_val("abort_ready_back", {31'd0, req_ready}, 32'd1);
    do_req("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h11111111, 1'b0, 0);

    chk_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
`default_nettype wire
